parking_sensor_conditioner: RTL

Front-end stage of the parking controller. It synchronises and debounces the raw entry/exit sensors and the 2-bit slot switch. It turns debounced sensor rising edges into discrete events and buffers them in a 4-deep FIFO with a valid/ack handshake. The occupancy FSM consumes one clean event per handshake instead of sampling raw, bouncing pins.

---
 rtl/parking_sensor_conditioner.sv | 119 +++++++++++
 1 files changed

// File: rtl/parking_sensor_conditioner.sv
// Sensor front end: synchronise and debounce raw pins, turn debounced rising edges of the
// entry/exit sensors into events, and queue them in a 4-entry FIFO with a valid/ack handshake.
module parking_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 400000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic [1:0] switch,
  input  logic       event_ack,
  output logic       entry_level,
  output logic       exit_level,
  output logic [1:0] switch_stable,
  output logic       event_valid,
  output logic [1:0] event_type,
  output logic [1:0] event_slot,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order: {switch[1], switch[0], exit, entry}
  logic [3:0]       raw, sync1, sync2, stable, stable_prev, rise;
  logic [CNT_W-1:0] cnt [4];

  logic             pend_entry, pend_exit, pend_entry_d, pend_exit_d;
  logic             ovf, ovf_d;
  logic [1:0]       rd_ptr, wr_ptr;
  logic [2:0]       count, count_d;
  logic [3:0]       fifo_mem [FIFO_DEPTH];
  logic [3:0]       head, push_data;
  logic             pop, push_ok, push_exit, push_entry, push;

  assign raw = {switch, exit_sensor, entry_sensor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stable & ~stable_prev;

  always_comb begin
    pop        = (count != 3'd0) && event_ack;
    push_ok    = (count < 3'(FIFO_DEPTH)) || pop;
    // Exit wins arbitration since it frees a slot
    push_exit  = push_ok && pend_exit;
    push_entry = push_ok && !pend_exit && pend_entry;
    push       = push_exit || push_entry;
    push_data  = {(push_exit ? 2'b10 : 2'b01), stable[3:2]};

    // A rise only drops when its flag will still be occupied after this cycle
    pend_exit_d  = (pend_exit && !push_exit) || rise[1];
    pend_entry_d = (pend_entry && !push_entry) || rise[0];
    ovf_d = ovf || (rise[1] && pend_exit && !push_exit) || (rise[0] && pend_entry && !push_entry);

    unique case ({push, pop})
      2'b10:   count_d = count + 3'd1;
      2'b01:   count_d = count - 3'd1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_prev <= '0;
      pend_entry  <= 1'b0;
      pend_exit   <= 1'b0;
      ovf         <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      stable_prev <= stable;
      pend_entry  <= pend_entry_d;
      pend_exit   <= pend_exit_d;
      ovf         <= ovf_d;
      count       <= count_d;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push) wr_ptr <= wr_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  assign head          = fifo_mem[rd_ptr];
  assign event_valid   = (count != 3'd0);
  assign event_type    = event_valid ? head[3:2] : 2'b00;
  assign event_slot    = event_valid ? head[1:0] : 2'b00;
  assign fifo_count    = count;
  assign overflow      = ovf;
  assign entry_level   = stable[0];
  assign exit_level    = stable[1];
  assign switch_stable = stable[3:2];

endmodule
